// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: one grant per cycle, 2-cycle grant-to-data pipeline into a synchronous ROM.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the highest requesting index wins.
module sprite_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    frame_start_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic                    rvalid_o,
  output logic [1:0]              rid_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    rom_en_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [DATA_W-1:0]       rom_data_i
);
  localparam int IDX_W = 2;

  logic [N_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [IDX_W-1:0]             gidx;
  logic                         gany;
  logic                         gnt_fire;
  logic [2:1]                   vld_pipe_q;  // [1]: ROM read cycle, [2]: data return cycle
  logic [IDX_W-1:0]             id1_q, rid_q;
  logic [ADDR_W-1:0]            rom_addr_q;

  assign addr_v = addr_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int k;
    logic [IDX_W-1:0] kidx;
    k    = 0;
    kidx = '0;
    gidx = '0;
    gany = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      kidx = IDX_W'(k);
      if (!gany && req_i[kidx]) begin
        gany = 1'b1;
        gidx = kidx;
      end
    end
  end

  // Frame start wins over the post-grant advance; the grant itself used the old pointer.
  always_comb begin
    ptr_d = ptr_q;
    if (frame_start_i)
      ptr_d = '0;
    else if (gnt_fire)
      ptr_d = (int'(gidx) == N_REQ-1) ? '0 : IDX_W'(int'(gidx) + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start_i;

  // Later (higher) indices overwrite earlier ones, so the highest requester wins.
  always_comb begin
    gidx = '0;
    gany = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[IDX_W'(i)]) begin
        gany = 1'b1;
        gidx = IDX_W'(i);
      end
    end
  end
`endif

  assign gnt_fire = gany & en_i & ~rst;
  assign gnt_o    = gnt_fire ? (N_REQ'(1) << gidx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      id1_q      <= '0;
      rid_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], gnt_fire};
      if (gnt_fire) begin
        id1_q      <= gidx;
        rom_addr_q <= addr_v[gidx];
      end
      if (vld_pipe_q[1]) rid_q <= id1_q;
    end
  end

  // Outputs are forced to reset values for the whole reset cycle, not just after the edge.
  assign rom_en_o   = vld_pipe_q[1] & ~rst;
  assign rom_addr_o = rst ? '0 : rom_addr_q;
  assign rvalid_o   = vld_pipe_q[2] & ~rst;
  assign rid_o      = rst ? '0 : rid_q;
  assign rdata_o    = rvalid_o ? rom_data_i : '0;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized + directed bench for sprite_rom_arbiter with an in-bench transaction model.
module tb_sprite_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic [3:0]  req_i = '0;
  logic [55:0] addr_i = '0;
  logic [3:0]  gnt_o;
  logic        rvalid_o;
  logic [1:0]  rid_o;
  logic [11:0] rdata_o;
  logic        rom_en_o;
  logic [13:0] rom_addr_o;
  logic [11:0] rom_data_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  sprite_rom_arbiter dut (
    .clk(clk), .rst(rst), .en_i(en_i), .frame_start_i(frame_start_i),
    .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rom_en_o(rom_en_o),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] romf(input logic [13:0] a);
    if (a == 14'h0123) return 12'hABC;
    return 12'(int'(a) * 5 + 7) ^ 12'h5A5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous ROM: address seen in one cycle produces data in the next.
  always @(negedge clk) begin
    logic       s_en;
    logic [13:0] s_a;
    s_en = rom_en_o;
    s_a  = rom_addr_o;
    @(posedge clk);
    #1;
    if (s_en) rom_data_i = romf(s_a);
  end

  // Reference model: list of granted reads, each tagged with its grant cycle.
  typedef struct { int gc; int idx; logic [13:0] a; } rd_t;
  rd_t         q[$];
  int          mc = 0;
  logic [13:0] m_last = '0;
`ifdef ARB_ROUND_ROBIN_EN
  int          m_ptr = 0;
`endif

  always @(negedge clk) begin
    logic [3:0]  eg;
    int          w;
    bit          e_en, e_v;
    logic [13:0] e_a;
    int          e_id;
    logic [11:0] e_d;
    eg = '0;
    w  = -1;
    if (!rst && en_i && req_i != 4'd0) begin
`ifdef ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 4; i++)
        if (w < 0 && req_i[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
`else
      for (int i = 3; i >= 0; i--)
        if (w < 0 && req_i[i]) w = i;
`endif
      eg[w] = 1'b1;
    end
    e_en = 0; e_v = 0; e_a = m_last; e_id = 0; e_d = '0;
    if (rst) begin
      q.delete();
      m_last = '0;
      e_a    = '0;
`ifdef ARB_ROUND_ROBIN_EN
      m_ptr  = 0;
`endif
    end else begin
      foreach (q[j]) begin
        if (q[j].gc == mc - 1) begin e_en = 1; e_a = q[j].a; end
        if (q[j].gc == mc - 2) begin e_v = 1; e_id = q[j].idx; e_d = romf(q[j].a); end
      end
      m_last = e_a;
    end
    chk("m_gnt", 32'(gnt_o), 32'(eg));
    chk("m_rom_en", 32'(rom_en_o), 32'(e_en));
    chk("m_rom_addr", 32'(rom_addr_o), 32'(e_a));
    chk("m_rvalid", 32'(rvalid_o), 32'(e_v));
    chk("m_rdata", 32'(rdata_o), 32'(e_d));
    if (e_v || rst) chk("m_rid", 32'(rid_o), 32'(e_id));
    if (w >= 0) q.push_back('{mc, w, addr_i[w*14 +: 14]});
`ifdef ARB_ROUND_ROBIN_EN
    if (!rst) begin
      if (frame_start_i) m_ptr = 0;
      else if (w >= 0)   m_ptr = (w + 1) % 4;
    end
`endif
    while (q.size() > 0 && q[0].gc < mc - 1) void'(q.pop_front());
    mc++;
  end

  // Apply one cycle of inputs, then return mid-cycle where outputs are settled.
  task automatic drive(input bit r, input bit e, input bit f, input logic [3:0] rq, input logic [55:0] ad);
    @(posedge clk);
    #2;
    rst = r; en_i = e; frame_start_i = f; req_i = rq; addr_i = ad;
    #5;
  endtask

  function automatic logic [55:0] rnd_addr();
    logic [55:0] v;
    for (int k = 0; k < 4; k++) v[k*14 +: 14] = 14'($urandom_range(0, 16383));
    return v;
  endfunction

  initial begin
    logic [55:0] ad;
    logic [3:0]  pend, rq;
    logic [3:0]  exp_g;
    int          exp_id;

    for (int i = 0; i < 3; i++) drive(1, 1, 0, 4'hF, rnd_addr());
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_rom_en", 32'(rom_en_o), 0);
    chk("rst_rom_addr", 32'(rom_addr_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_rid", 32'(rid_o), 0);
    chk("rst_rdata", 32'(rdata_o), 0);

    // Single request, first cycle out of reset
    ad = rnd_addr();
    ad[2*14 +: 14] = 14'h0123;
    drive(0, 1, 0, 4'b0100, ad);
    chk("single_gnt", 32'(gnt_o), 32'h4);
    drive(0, 1, 1, 4'b0000, rnd_addr());
    chk("single_rom_en", 32'(rom_en_o), 1);
    chk("single_rom_addr", 32'(rom_addr_o), 32'h0123);

    // All four requesting back-to-back
    for (int j = 0; j < 7; j++) begin
      drive(0, 1, 0, (j < 5) ? 4'hF : 4'h0, rnd_addr());
      if (j == 0) begin
        chk("single_rvalid", 32'(rvalid_o), 1);
        chk("single_rid", 32'(rid_o), 2);
        chk("single_rdata", 32'(rdata_o), 32'hABC);
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_g  = 4'(1 << (j % 4));
      exp_id = (j + 2) % 4;
`else
      exp_g  = 4'b1000;
      exp_id = 3;
`endif
      if (j < 5)  chk("all_gnt", 32'(gnt_o), 32'(exp_g));
      if (j >= 2) begin
        chk("all_rvalid", 32'(rvalid_o), 1);
        chk("all_rid", 32'(rid_o), 32'(exp_id));
      end
    end

    // Enable drop: in-flight reads drain
    for (int j = 0; j < 3; j++) drive(0, 1, 0, 4'hF, rnd_addr());
    drive(0, 0, 0, 4'hF, rnd_addr());
    chk("drain_gnt", 32'(gnt_o), 0);
    chk("drain_rvalid0", 32'(rvalid_o), 1);
    chk("drain_rom_en", 32'(rom_en_o), 1);
    drive(0, 0, 0, 4'hF, rnd_addr());
    chk("drain_rvalid1", 32'(rvalid_o), 1);
    chk("drain_rom_en_off", 32'(rom_en_o), 0);
    drive(0, 0, 0, 4'h0, rnd_addr());
    chk("drain_rvalid_off", 32'(rvalid_o), 0);

    // Reset right after a grant flushes it
    drive(0, 1, 0, 4'b0001, rnd_addr());
    chk("flush_gnt", 32'(gnt_o), 1);
    drive(1, 1, 0, 4'hF, rnd_addr());
    chk("flush_rst_gnt", 32'(gnt_o), 0);
    chk("flush_rst_rom_en", 32'(rom_en_o), 0);
    drive(0, 1, 0, 4'h0, rnd_addr());
    chk("flush_rvalid", 32'(rvalid_o), 0);
    chk("flush_rom_en", 32'(rom_en_o), 0);
    chk("flush_rom_addr", 32'(rom_addr_o), 0);

    // Frame start coincident with a grant to index 1
    drive(0, 1, 0, 4'b0001, rnd_addr());
    drive(0, 1, 1, 4'b0010, rnd_addr());
    chk("frame_gnt", 32'(gnt_o), 32'h2);
    drive(0, 1, 0, 4'hF, rnd_addr());
`ifdef ARB_ROUND_ROBIN_EN
    chk("frame_next_gnt", 32'(gnt_o), 32'h1);
`else
    chk("frame_next_gnt", 32'(gnt_o), 32'h8);
`endif
    drive(0, 1, 0, 4'h0, rnd_addr());
    drive(0, 1, 0, 4'h0, rnd_addr());

    // Random traffic: pending requests keep their address, may be withdrawn
    pend = '0;
    ad   = rnd_addr();
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (pend[k]) rq[k] = ($urandom_range(0, 7) != 0);
        else begin
          rq[k] = $urandom_range(0, 1) == 1;
          ad[k*14 +: 14] = 14'($urandom_range(0, 16383));
        end
      end
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 15) == 0, rq, ad);
      pend = req_i & ~gnt_o;
    end

    for (int j = 0; j < 3; j++) drive(0, 0, 0, 4'h0, ad);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
